// File: rtl/BundleParam.sv
// Shared TileLink bundle widths for the D/E sink path.
// Beat geometry is derived from the data bus width.
package BundleParam;

   localparam int DATA_BITS   = 64;
   localparam int SOURCE_BITS = 4;
   localparam int SINK_BITS   = 3;
   localparam int SIZE_BITS   = 4;
   localparam int BEAT_BYTES  = DATA_BITS / 8;
   localparam int LG_BEAT     = $clog2(BEAT_BYTES);

   localparam logic [SIZE_BITS-1:0] LG_BEAT_S = SIZE_BITS'(LG_BEAT);

endpackage

// File: rtl/BundleST.sv
// TileLink D and E channel bundle types.
// Field widths come from BundleParam.
package BundleST;

   import BundleParam::*;

   typedef struct packed {
      logic [2:0]             opcode;
      logic [1:0]             param;
      logic [SIZE_BITS-1:0]   size;
      logic [SOURCE_BITS-1:0] source;
      logic [SINK_BITS-1:0]   sink;
      logic                   denied;
      logic [DATA_BITS-1:0]   data;
      logic                   corrupt;
   } TLBundleDST;

   typedef struct packed {
      logic [SINK_BITS-1:0] sink;
   } TLBundleEST;

endpackage

// File: rtl/TLMessages.sv
// TileLink D-channel opcodes and burst length helper.
// Shared by every D-channel consumer.
package TLMessages;

   import BundleParam::*;

   localparam logic [2:0] AccessAck     = 3'd0;
   localparam logic [2:0] AccessAckData = 3'd1;
   localparam logic [2:0] HintAck       = 3'd2;
   localparam logic [2:0] Grant         = 3'd4;
   localparam logic [2:0] GrantData     = 3'd5;
   localparam logic [2:0] ReleaseAck    = 3'd6;

   // Number of beats carried by a D message of this opcode/size.
   function automatic logic [15:0] tl_d_beats(
      input logic [2:0]           opcode,
      input logic [SIZE_BITS-1:0] size
   );
      logic has_data;
      has_data = (opcode == AccessAckData) || (opcode == GrantData);
      if (has_data && (size > LG_BEAT_S)) begin
         tl_d_beats = 16'd1 << (size - LG_BEAT_S);
      end else begin
         tl_d_beats = 16'd1;
      end
   endfunction

endpackage

// File: rtl/tl_e_ack_fifo.sv
// Pending GrantAck FIFO: sink ids in Grant order.
// Pointers carry one extra wrap bit to tell full from empty.
module tl_e_ack_fifo
   import BundleST::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       push,
   input  TLBundleEST push_data,
   input  logic       pop,
   output logic       full,
   output logic       empty,
   output TLBundleEST head
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        do_push, do_pop;
   TLBundleEST  mem_q [DEPTH];

   // Status flags, head read and pointer advance.
   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      do_push  = push && !full;
      do_pop   = pop && !empty;
      head     = mem_q[rd_ptr_q[AW-1:0]];
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   // Pointer registers; reset empties the queue.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: entries are only read once pushed.
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/tl_d_grant_ack_gen.sv
// Client D-channel sink: beat tracking plus GrantAck generation on E.
// Optional burst consistency checker enabled by TL_D_CHECK_EN.
module tl_d_grant_ack_gen
   import BundleParam::*;
   import BundleST::*;
   import TLMessages::*;
#(
   parameter int ACK_DEPTH  = 4,
   parameter int BEAT_CNT_W = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       d_in_valid,
   output logic       d_in_ready,
   input  TLBundleDST d_in_bits,
   output logic       d_out_valid,
   input  logic       d_out_ready,
   output TLBundleDST d_out_bits,
   output logic       d_out_first,
   output logic       d_out_last,
   output logic       e_valid,
   input  logic       e_ready,
   output TLBundleEST e_bits,
   output logic       proto_err
);

   logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [15:0]           beats;
   logic                  first, last, is_grant, stall, fire;
   logic                  ack_full, ack_empty, ack_push, ack_pop;
   TLBundleEST            ack_in, ack_head;

   // Beat position, backpressure and the GrantAck push decision.
   always_comb begin
      beats    = tl_d_beats(d_in_bits.opcode, d_in_bits.size);
      first    = (beat_cnt_q == '0);
      last     = (16'(beat_cnt_q) == (beats - 16'd1));
      is_grant = (d_in_bits.opcode == Grant) ||
                 (d_in_bits.opcode == GrantData);
      // Full blocks even if the head pops this cycle: keeps e_ready
      // out of the d_in_ready cone at the cost of one bubble.
      stall       = is_grant && last && ack_full;
      d_out_valid = !reset && d_in_valid && !stall;
      d_in_ready  = !reset && d_out_ready && !stall;
      fire        = d_in_valid && d_in_ready;
      beat_cnt_d  = beat_cnt_q;
      if (fire) begin
         beat_cnt_d = last ? '0 : beat_cnt_q + 1'b1;
      end
      ack_push    = fire && is_grant && last;
      ack_in.sink = d_in_bits.sink;
      ack_pop     = e_valid && e_ready;
      d_out_bits  = d_in_bits;
      d_out_first = first;
      d_out_last  = last;
      e_valid     = !ack_empty;
      e_bits      = ack_head;
   end

   // Beat counter; reset abandons any burst in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) beat_cnt_q <= '0;
      else       beat_cnt_q <= beat_cnt_d;
   end

   tl_e_ack_fifo #(
      .DEPTH(ACK_DEPTH)
   ) u_ack_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (ack_push),
      .push_data(ack_in),
      .pop      (ack_pop),
      .full     (ack_full),
      .empty    (ack_empty),
      .head     (ack_head)
   );

`ifdef TL_D_CHECK_EN
   logic [2:0]             cap_op_q, cap_op_d;
   logic [SIZE_BITS-1:0]   cap_size_q, cap_size_d;
   logic [SOURCE_BITS-1:0] cap_src_q, cap_src_d;
   logic                   err_q, err_d;

   // Capture header on the first beat, flag any drift on later beats.
   always_comb begin
      cap_op_d   = cap_op_q;
      cap_size_d = cap_size_q;
      cap_src_d  = cap_src_q;
      err_d      = err_q;
      if (fire) begin
         if (first) begin
            cap_op_d   = d_in_bits.opcode;
            cap_size_d = d_in_bits.size;
            cap_src_d  = d_in_bits.source;
         end else if ((d_in_bits.opcode != cap_op_q) ||
                      (d_in_bits.size != cap_size_q) ||
                      (d_in_bits.source != cap_src_q)) begin
            err_d = 1'b1;
         end
         if (int'(d_in_bits.size) > (LG_BEAT + BEAT_CNT_W)) begin
            err_d = 1'b1;
         end
      end
   end

   // Checker state; the error flag is sticky until reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cap_op_q   <= '0;
         cap_size_q <= '0;
         cap_src_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         cap_op_q   <= cap_op_d;
         cap_size_q <= cap_size_d;
         cap_src_q  <= cap_src_d;
         err_q      <= err_d;
      end
   end

   assign proto_err = err_q;
`else
   assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_tl_d_grant_ack_gen.sv
// Directed bench for tl_d_grant_ack_gen with D/E scoreboards.
// Expected proto_err follows TL_D_CHECK_EN.
module tb_tl_d_grant_ack_gen;

   import BundleParam::*;
   import BundleST::*;

   typedef struct packed {
      TLBundleDST bits;
      logic       first;
      logic       last;
   } d_exp_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       d_in_valid, d_in_ready;
   TLBundleDST d_in_bits, d_out_bits;
   logic       d_out_valid, d_out_ready, d_out_first, d_out_last;
   logic       e_valid, e_ready, proto_err;
   TLBundleEST e_bits;

   d_exp_t               d_q[$];
   logic [SINK_BITS-1:0] e_q[$];
   d_exp_t               d_exp;
   logic [SINK_BITS-1:0] e_exp;
   int                   checks = 0;
   int                   failures = 0;
   logic                 rand_mode = 1'b0;
   logic                 exp_err;

   tl_d_grant_ack_gen #(
      .ACK_DEPTH (4),
      .BEAT_CNT_W(8)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .d_in_valid (d_in_valid),
      .d_in_ready (d_in_ready),
      .d_in_bits  (d_in_bits),
      .d_out_valid(d_out_valid),
      .d_out_ready(d_out_ready),
      .d_out_bits (d_out_bits),
      .d_out_first(d_out_first),
      .d_out_last (d_out_last),
      .e_valid    (e_valid),
      .e_ready    (e_ready),
      .e_bits     (e_bits),
      .proto_err  (proto_err)
   );

   always #5 clock = ~clock;

   // Scoreboard: compare each accepted D beat and E ack against the queues.
   always @(negedge clock) begin
      if (!reset && d_out_valid && d_out_ready) begin
         checks++;
         assert (d_q.size() != 0) else begin
            failures++;
            $error("FAIL d_extra observed=%h expected=none", d_out_bits);
         end
         if (d_q.size() != 0) begin
            d_exp = d_q.pop_front();
            checks++;
            assert ({d_out_bits, d_out_first, d_out_last} === d_exp) else begin
               failures++;
               $error("FAIL d_beat observed=%h/%b%b expected=%h/%b%b",
                      d_out_bits, d_out_first, d_out_last,
                      d_exp.bits, d_exp.first, d_exp.last);
            end
         end
      end
      if (!reset && e_valid && e_ready) begin
         checks++;
         assert (e_q.size() != 0) else begin
            failures++;
            $error("FAIL e_extra observed=%0d expected=none", e_bits.sink);
         end
         if (e_q.size() != 0) begin
            e_exp = e_q.pop_front();
            checks++;
            assert (e_bits.sink === e_exp) else begin
               failures++;
               $error("FAIL e_sink observed=%0d expected=%0d", e_bits.sink, e_exp);
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      if (rand_mode) d_out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_fire();
      int n = 0;
      forever begin
         @(negedge clock);
         if (d_in_valid && d_in_ready) break;
         n++;
         if (n > 200) begin
            checks++;
            failures++;
            $error("FAIL fire_timeout observed=no_fire expected=fire");
            break;
         end
         step();
      end
      step();
      d_in_valid = 1'b0;
   endtask

   task automatic send_beat(input logic [2:0] op, input logic [3:0] size,
                            input logic [2:0] sink, input logic [3:0] src,
                            input logic den, input logic first,
                            input logic last);
      TLBundleDST b;
      b        = '0;
      b.opcode = op;
      b.size   = size;
      b.sink   = sink;
      b.source = src;
      b.denied = den;
      b.data   = {$urandom, $urandom};
      if (rand_mode && ($urandom_range(0, 1) == 1)) begin
         d_in_valid = 1'b0;
         step();
      end
      d_q.push_back('{b, first, last});
      if (last && ((op == 3'd4) || (op == 3'd5))) e_q.push_back(sink);
      d_in_bits  = b;
      d_in_valid = 1'b1;
      wait_fire();
   endtask

   task automatic send_msg(input logic [2:0] op, input logic [3:0] size,
                           input logic [2:0] sink, input logic den);
      int n;
      n = (((op == 3'd1) || (op == 3'd5)) && (size > 4'd3)) ? (1 << (size - 4'd3)) : 1;
      for (int i = 0; i < n; i++) begin
         send_beat(op, size, sink, 4'd1, den, i == 0, i == n - 1);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 100; i++) begin
         if (d_q.size() == 0 && e_q.size() == 0) break;
         step();
      end
      chk("d_queue_empty", d_q.size(), 0);
      chk("e_queue_empty", e_q.size(), 0);
   endtask

   initial begin
      TLBundleDST b;
      reset       = 1'b1;
      d_in_valid  = 1'b1;
      d_in_bits   = '0;
      d_out_ready = 1'b1;
      e_ready     = 1'b1;
      #12;
      chk("rst_d_in_ready", d_in_ready, 0);
      chk("rst_d_out_valid", d_out_valid, 0);
      chk("rst_e_valid", e_valid, 0);
      chk("rst_proto_err", proto_err, 0);
      d_in_valid = 1'b0;
      step();
      reset = 1'b0;
      step();

      // 8-beat GrantData; E one cycle after the last beat.
      send_msg(3'd5, 4'd6, 3'd3, 1'b0);
      chk("e_valid_lat", e_valid, 1);
      chk("e_sink_lat", e_bits.sink, 3);
      drain();
      chk("e_idle", e_valid, 0);

      // Single-beat messages, incl. denied Grant and data-less AccessAck.
      send_msg(3'd4, 4'd6, 3'd5, 1'b0);
      send_msg(3'd1, 4'd3, 3'd1, 1'b0);
      send_msg(3'd0, 4'd6, 3'd6, 1'b0);
      send_msg(3'd4, 4'd2, 3'd2, 1'b1);
      drain();

      // Fill the ack FIFO, then a fifth Grant must stall.
      e_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_msg(3'd4, 4'd6, 3'(i), 1'b0);
      chk("full_e_valid", e_valid, 1);
      chk("full_e_head", e_bits.sink, 0);
      b        = '0;
      b.opcode = 3'd4;
      b.size   = 4'd6;
      b.sink   = 3'd4;
      d_q.push_back('{b, 1'b1, 1'b1});
      e_q.push_back(3'd4);
      d_in_bits  = b;
      d_in_valid = 1'b1;
      repeat (3) step();
      chk("stall_d_in_ready", d_in_ready, 0);
      chk("stall_d_out_valid", d_out_valid, 0);
      e_ready = 1'b1;
      wait_fire();
      drain();

      // Random backpressure and gaps during a burst.
      rand_mode = 1'b1;
      send_msg(3'd5, 4'd6, 3'd6, 1'b0);
      rand_mode   = 1'b0;
      d_out_ready = 1'b1;
      drain();

      // Reset mid-burst with two acks pending.
      e_ready = 1'b0;
      send_msg(3'd4, 4'd6, 3'd1, 1'b0);
      send_msg(3'd4, 4'd6, 3'd2, 1'b0);
      for (int i = 0; i < 4; i++) begin
         send_beat(3'd5, 4'd6, 3'd7, 4'd1, 1'b0, i == 0, 1'b0);
      end
      b          = '0;
      b.opcode   = 3'd5;
      b.size     = 4'd6;
      d_in_bits  = b;
      d_in_valid = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_d_out_valid", d_out_valid, 0);
      chk("mid_rst_d_in_ready", d_in_ready, 0);
      chk("mid_rst_e_valid", e_valid, 0);
      e_q.delete();
      d_in_valid = 1'b0;
      step();
      reset   = 1'b0;
      e_ready = 1'b1;
      repeat (3) step();
      chk("post_rst_e_valid", e_valid, 0);
      send_msg(3'd4, 4'd6, 3'd5, 1'b0);
      drain();

      // Source changes on beat 2 of a burst.
`ifdef TL_D_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      chk("pre_proto_err", proto_err, 0);
      for (int i = 0; i < 8; i++) begin
         send_beat(3'd5, 4'd6, 3'd2, (i == 2) ? 4'd9 : 4'd1, 1'b0, i == 0, i == 7);
      end
      chk("proto_err", proto_err, 32'(exp_err));
      send_msg(3'd4, 4'd6, 3'd3, 1'b0);
      chk("proto_err_sticky", proto_err, 32'(exp_err));
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
